// File: rtl/fpga_robots_game_serial_pkg.sv
// Shared serial-link definitions: FSM state encodings and frame constants.
// Used by the transmitter and the future receiver.
package fpga_robots_game_serial_pkg;

  localparam int DATA_BITS = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } ser_state_t;

endpackage

// File: rtl/fpga_robots_game_fifo8.sv
// Synchronous byte FIFO, depth 2**LOG2, head byte readable combinationally.
// Full/empty come from the registered count, so a write when full is dropped.
module fpga_robots_game_fifo8 #(
  parameter int LOG2 = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [7:0]    wr_dat,
  input  logic          rd_en,
  output logic [7:0]    rd_dat,
  output logic [LOG2:0] cnt,
  output logic          full,
  output logic          empty
);

  localparam int DEPTH = 1 << LOG2;

  logic [7:0]      mem [DEPTH];
  logic [LOG2-1:0] wr_ptr;
  logic [LOG2-1:0] rd_ptr;
  logic            push;
  logic            pop;

  assign full   = (cnt == (LOG2+1)'(DEPTH));
  assign empty  = (cnt == '0);
  assign push   = wr_en && !full;
  assign pop    = rd_en && !empty;
  assign rd_dat = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_dat;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + LOG2'(1);
      if (pop)  rd_ptr <= rd_ptr + LOG2'(1);
      case ({push, pop})
        2'b10:   cnt <= cnt + (LOG2+1)'(1);
        2'b01:   cnt <= cnt - (LOG2+1)'(1);
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/fpga_robots_game_serial_tx.sv
// UART transmitter for the host link: 8N1/8N2, LSB first, idle high.
// Bytes queue in a FIFO; every bit advances on a baud1 strobe.
import fpga_robots_game_serial_pkg::*;

module fpga_robots_game_serial_tx #(
  parameter int FIFO_LOG2 = 4,
  parameter int STOP_BITS = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               baud1,
  input  logic [7:0]         wr_dat,
  input  logic               wr_en,
  output logic               wr_rdy,
  output logic [FIFO_LOG2:0] fifo_cnt,
  output logic               busy,
  output logic               serial_tx
);

  ser_state_t state;
  ser_state_t state_nxt;
  logic [7:0] shift;
  logic [7:0] shift_nxt;
  logic [2:0] bit_cnt;
  logic [2:0] bit_cnt_nxt;
  logic [1:0] stop_cnt;
  logic [1:0] stop_cnt_nxt;
  logic       tx_nxt;
  logic       pop;
  logic [7:0] head;
  logic       full;
  logic       empty;

  fpga_robots_game_fifo8 #(
    .LOG2(FIFO_LOG2)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .wr_en (wr_en),
    .wr_dat(wr_dat),
    .rd_en (pop),
    .rd_dat(head),
    .cnt   (fifo_cnt),
    .full  (full),
    .empty (empty)
  );

  assign wr_rdy = !full;
  assign busy   = (state != IDLE) || !empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      shift     <= '0;
      bit_cnt   <= '0;
      stop_cnt  <= '0;
      serial_tx <= 1'b1;
    end else begin
      state     <= state_nxt;
      shift     <= shift_nxt;
      bit_cnt   <= bit_cnt_nxt;
      stop_cnt  <= stop_cnt_nxt;
      serial_tx <= tx_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    shift_nxt    = shift;
    bit_cnt_nxt  = bit_cnt;
    stop_cnt_nxt = stop_cnt;
    tx_nxt       = serial_tx;
    pop          = 1'b0;
    if (baud1) begin
      unique case (state)
        IDLE: begin
          tx_nxt = 1'b1;
          if (!empty) begin
            pop       = 1'b1;
            shift_nxt = head;
            tx_nxt    = 1'b0;
            state_nxt = START;
          end
        end
        START: begin
          tx_nxt      = shift[0];
          bit_cnt_nxt = '0;
          state_nxt   = DATA;
        end
        DATA: begin
          if (bit_cnt != 3'(DATA_BITS - 1)) begin
            shift_nxt   = {1'b0, shift[7:1]};
            tx_nxt      = shift[1];
            bit_cnt_nxt = bit_cnt + 3'd1;
          end else begin
            tx_nxt       = 1'b1;
            stop_cnt_nxt = 2'd1;
            state_nxt    = STOP;
          end
        end
        STOP: begin
          if (stop_cnt < 2'(STOP_BITS)) begin
            stop_cnt_nxt = stop_cnt + 2'd1;
          end else if (!empty) begin
            // next frame starts right after the stop bit
            pop       = 1'b1;
            shift_nxt = head;
            tx_nxt    = 1'b0;
            state_nxt = START;
          end else begin
            state_nxt = IDLE;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fpga_robots_game_serial_tx.sv
// Bench for the UART transmitter: frame vectors, back-to-back,
// FIFO full/drop, mid-frame reset, and a 2-stop-bit instance.
module tb_fpga_robots_game_serial_tx;

  logic       clk = 1'b0;
  logic       rst;
  logic       baud1;
  logic [7:0] wr_dat;
  logic       wr_en;
  logic       wr_rdy;
  logic [4:0] fifo_cnt;
  logic       busy;
  logic       serial_tx;
  logic [7:0] wr_dat2;
  logic       wr_en2;
  logic       wr_rdy2;
  logic [4:0] fifo_cnt2;
  logic       busy2;
  logic       serial_tx2;

  fpga_robots_game_serial_tx #(
    .FIFO_LOG2(4),
    .STOP_BITS(1)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .baud1    (baud1),
    .wr_dat   (wr_dat),
    .wr_en    (wr_en),
    .wr_rdy   (wr_rdy),
    .fifo_cnt (fifo_cnt),
    .busy     (busy),
    .serial_tx(serial_tx)
  );

  fpga_robots_game_serial_tx #(
    .FIFO_LOG2(4),
    .STOP_BITS(2)
  ) dut2 (
    .clk      (clk),
    .rst      (rst),
    .baud1    (baud1),
    .wr_dat   (wr_dat2),
    .wr_en    (wr_en2),
    .wr_rdy   (wr_rdy2),
    .fifo_cnt (fifo_cnt2),
    .busy     (busy2),
    .serial_tx(serial_tx2)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    int         div;
    logic [9:0] line;
  } vec_t;

  vec_t vecs[5];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   div = 0;
  int   bphase = 0;
  int   glitches = 0;
  logic q1[$];
  logic q2[$];

  task automatic check(string name, int act, int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic timeout(string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: timed out waiting for line bits", name);
  endtask

  // One clk: record the line value that each baud1 strobe launches.
  task automatic step();
    logic b;
    logic prev;
    b    = baud1;
    prev = serial_tx;
    @(posedge clk);
    #1;
    if (b) begin
      q1.push_back(serial_tx);
      q2.push_back(serial_tx2);
    end else if (!rst && serial_tx !== prev) begin
      glitches++;
    end
    bphase++;
    baud1 = (div == 1) || (div > 1 && bphase % div == 0);
  endtask

  task automatic wait_bits(int n, int budget, string name);
    int c;
    c = 0;
    while (q1.size() < n && c < budget) begin
      step();
      c++;
    end
    if (q1.size() < n) timeout(name);
  endtask

  function automatic int qword(int s, int n, bit second);
    int w;
    w = 0;
    for (int i = 0; i < n; i++) begin
      if (second) w[i] = q2[s + i];
      else        w[i] = q1[s + i];
    end
    return w;
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
    q1.delete();
    q2.delete();
  endtask

  task automatic write(logic [7:0] d);
    wr_dat = d;
    wr_en  = 1'b1;
    step();
    wr_en  = 1'b0;
  endtask

  initial begin
    int c;
    int idx;
    int frames;
    int zeros;

    vecs[0] = '{8'h55, 4, 10'b1010101010};
    vecs[1] = '{8'h00, 1, 10'b1000000000};
    vecs[2] = '{8'hFF, 3, 10'b1111111110};
    vecs[3] = '{8'hA3, 2, 10'b1101000110};
    vecs[4] = '{8'h0F, 1, 10'b1000011110};

    rst     = 1'b1;
    baud1   = 1'b0;
    wr_en   = 1'b0;
    wr_dat  = 8'h00;
    wr_en2  = 1'b0;
    wr_dat2 = 8'h00;
    step();
    step();
    rst = 1'b0;
    check("rst_tx", serial_tx, 1);
    check("rst_cnt", fifo_cnt, 0);
    check("rst_rdy", wr_rdy, 1);
    check("rst_busy", busy, 0);

    // first baud strobe after the write launches the start bit
    div = 1;
    write(8'h3C);
    q1.delete();
    step();
    check("latency_start", serial_tx, 0);
    wait_bits(11, 50, "latency_drain");
    do_reset();

    for (int v = 0; v < 5; v++) begin
      div = vecs[v].div;
      write(vecs[v].data);
      q1.delete();
      c = 0;
      while (q1.size() < 11 && c < 300) begin
        step();
        c++;
        while (q1.size() > 0 && q1[0] == 1'b1)
          void'(q1.pop_front());
      end
      if (q1.size() < 11) begin
        timeout($sformatf("vec%0d", v));
      end else begin
        check($sformatf("vec%0d_frame", v),
              qword(0, 10, 0), int'(vecs[v].line));
        check($sformatf("vec%0d_idle", v), q1[10], 1);
        check($sformatf("vec%0d_busy", v), busy, 0);
      end
    end

    // back-to-back frames
    do_reset();
    div   = 0;
    baud1 = 1'b0;
    write(8'hA3);
    write(8'h0F);
    check("b2b_cnt2", fifo_cnt, 2);
    q1.delete();
    div    = 4;
    bphase = 0;
    wait_bits(1, 20, "b2b_pop1");
    check("b2b_cnt1", fifo_cnt, 1);
    wait_bits(11, 60, "b2b_pop2");
    check("b2b_cnt0", fifo_cnt, 0);
    wait_bits(21, 60, "b2b_end");
    if (q1.size() >= 21) begin
      check("b2b_bits", qword(0, 20, 0),
            {12'd0, 10'b1000011110, 10'b1101000110});
      check("b2b_idle", q1[20], 1);
    end
    check("b2b_busy", busy, 0);

    // fill with baud1 held low; 17th write is dropped
    do_reset();
    div   = 0;
    baud1 = 1'b0;
    for (int i = 0; i < 17; i++) begin
      write(8'h10 + 8'(i));
      if (i == 14) check("fill_rdy15", wr_rdy, 1);
      if (i == 15) check("fill_rdy16", wr_rdy, 0);
    end
    check("fill_cnt", fifo_cnt, 16);
    q1.delete();
    div = 1;
    c   = 0;
    step();
    while (busy && c < 400) begin
      step();
      c++;
    end
    if (busy) timeout("fill_drain");
    idx    = 0;
    frames = 0;
    while (idx < q1.size()) begin
      if (q1[idx] == 1'b1) begin
        idx++;
      end else if (idx + 9 < q1.size()) begin
        check($sformatf("fill_byte%0d", frames),
              qword(idx + 1, 8, 0), 8'h10 + frames);
        check($sformatf("fill_stop%0d", frames),
              q1[idx + 9], 1);
        frames++;
        idx += 10;
      end else begin
        idx = q1.size();
      end
    end
    check("fill_frames", frames, 16);

    // full FIFO, write and pop in the same cycle
    do_reset();
    div   = 0;
    baud1 = 1'b0;
    for (int i = 0; i < 16; i++) write(8'h40 + 8'(i));
    check("fullpop_cnt16", fifo_cnt, 16);
    baud1 = 1'b1;
    write(8'hEE);
    check("fullpop_cnt15", fifo_cnt, 15);
    check("fullpop_rdy", wr_rdy, 1);

    // reset during data bit 3 of 0xFF with 5 bytes queued
    do_reset();
    div   = 0;
    baud1 = 1'b0;
    write(8'hFF);
    for (int i = 1; i <= 5; i++) write(8'(i));
    check("rstmid_cnt6", fifo_cnt, 6);
    q1.delete();
    div = 4;
    wait_bits(5, 40, "rstmid_bit3");
    check("rstmid_state", busy, 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rstmid_tx", serial_tx, 1);
    check("rstmid_cnt", fifo_cnt, 0);
    check("rstmid_busy", busy, 0);
    check("rstmid_rdy", wr_rdy, 1);
    q1.delete();
    for (int i = 0; i < 200; i++) step();
    zeros = 0;
    foreach (q1[i]) if (q1[i] == 1'b0) zeros++;
    check("rstmid_silent", zeros, 0);

    // two stop bits
    do_reset();
    div   = 0;
    baud1 = 1'b0;
    wr_dat2 = 8'h00;
    wr_en2  = 1'b1;
    step();
    step();
    wr_en2  = 1'b0;
    check("stop2_cnt", fifo_cnt2, 2);
    q1.delete();
    q2.delete();
    div = 4;
    wait_bits(23, 150, "stop2_end");
    if (q2.size() >= 23) begin
      check("stop2_bits", qword(0, 22, 1),
            {10'd0, 11'b11000000000, 11'b11000000000});
      check("stop2_idle", q2[22], 1);
    end
    check("stop2_busy", busy2, 0);

    check("no_glitch", glitches, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
